// File: rtl/ts_byte2word_packer_pkg.sv
// Shared TS framing constants and helpers for the j83 byte-to-word packer.
// TS_PKT_BYTES / TS_SYNC_BYTE are the same values used by the DDR3 read/write control.
package ts_byte2word_packer_pkg;
    localparam int         TS_PKT_BYTES = 188;
    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

    typedef enum logic {IDLE, PACK} state_t;

    // Place a byte in its big-endian lane of a 32-bit word, other lanes zero.
    function automatic logic [31:0] lane_place(input logic [7:0] b, input logic [1:0] lane);
        return {b, 24'h0} >> {lane, 3'b000};
    endfunction
endpackage

// File: rtl/ts_byte2word_packer_if.sv
// sc-style stream bundle (d/dval/sop/eop); DW=8 for the TS byte side, DW=32 for the word side.
interface ts_byte2word_packer_if #(parameter int DW = 8);
    logic [DW-1:0] d;
    logic          dval;
    logic          sop;
    logic          eop;

    modport master (output d, dval, sop, eop);
    modport slave  (input  d, dval, sop, eop);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   q <= '0;
        else if (clr)              q <= '0;
        else if (inc && (q != '1)) q <= q + 1'b1;
    end
endmodule

// File: rtl/ts_byte2word_packer.sv
// Packs the TS byte stream into 32-bit big-endian sc words with word-level sop/eop,
// enforcing packet length and sync byte, and counting good packets and framing errors.
module ts_byte2word_packer
    import ts_byte2word_packer_pkg::*;
#(
    parameter int         PKT_BYTES = TS_PKT_BYTES,
    parameter logic [7:0] SYNC_BYTE = TS_SYNC_BYTE,
    parameter bit         CHK_SYNC  = 1'b1,
    parameter int         CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    ts_byte2word_packer_if.slave    ts_i,
    ts_byte2word_packer_if.master   sc_o,
    input  logic                    cnt_clr,
    output logic                    pkt_err,
    output logic [CNT_W-1:0]        pkt_cnt,
    output logic [CNT_W-1:0]        err_cnt
);
    localparam int BCW = $clog2(PKT_BYTES);

    state_t         state;
    logic [BCW-1:0] byte_cnt;
    logic [31:0]    pack, wnext, sc_d;
    logic           sc_dval, sc_sop, sc_eop;
    logic           first;
    logic           hold_vld, hold_word;
    logic [7:0]     hold_b;
    logic           pkt_ok;
    logic [1:0]     lane;
    logic           sync_ok, last;

    assign lane    = byte_cnt[1:0];
    assign sync_ok = (ts_i.d == SYNC_BYTE) || !CHK_SYNC;
    assign last    = (byte_cnt == BCW'(PKT_BYTES - 1));
    assign wnext   = pack | lane_place(ts_i.d, lane);

    assign sc_o.d    = sc_d;
    assign sc_o.dval = sc_dval;
    assign sc_o.sop  = sc_sop;
    assign sc_o.eop  = sc_eop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            pack      <= '0;
            first     <= 1'b0;
            hold_vld  <= 1'b0;
            hold_word <= 1'b0;
            hold_b    <= '0;
            sc_d      <= '0;
            sc_dval   <= 1'b0;
            sc_sop    <= 1'b0;
            sc_eop    <= 1'b0;
            pkt_err   <= 1'b0;
            pkt_ok    <= 1'b0;
        end else begin
            sc_dval <= 1'b0;
            sc_sop  <= 1'b0;
            sc_eop  <= 1'b0;
            pkt_err <= 1'b0;
            pkt_ok  <= 1'b0;
            if (hold_vld) begin
                // Second half of a mid-packet sop: the sop byte's own error, plus its 1-byte word.
                hold_vld <= 1'b0;
                pkt_err  <= 1'b1;
                if (hold_word) begin
                    sc_d    <= {hold_b, 24'h0};
                    sc_dval <= 1'b1;
                    sc_sop  <= 1'b1;
                    sc_eop  <= 1'b1;
                end
            end else if (ts_i.dval) begin
                case (state)
                    IDLE: begin
                        if (ts_i.sop) begin
                            if (!sync_ok) begin
                                pkt_err <= 1'b1;
                            end else if (ts_i.eop) begin
                                sc_d    <= {ts_i.d, 24'h0};
                                sc_dval <= 1'b1;
                                sc_sop  <= 1'b1;
                                sc_eop  <= 1'b1;
                                pkt_err <= 1'b1;
                            end else begin
                                pack     <= {ts_i.d, 24'h0};
                                byte_cnt <= BCW'(1);
                                first    <= 1'b1;
                                state    <= PACK;
                            end
                        end
                    end
                    PACK: begin
                        if (ts_i.sop) begin
                            sc_d     <= pack;
                            sc_dval  <= 1'b1;
                            sc_sop   <= first;
                            sc_eop   <= 1'b1;
                            pkt_err  <= 1'b1;
                            pack     <= '0;
                            byte_cnt <= '0;
                            state    <= IDLE;
                            if (sync_ok && !ts_i.eop) begin
                                pack     <= {ts_i.d, 24'h0};
                                byte_cnt <= BCW'(1);
                                first    <= 1'b1;
                                state    <= PACK;
                            end else begin
                                hold_vld  <= 1'b1;
                                hold_word <= sync_ok;
                                hold_b    <= ts_i.d;
                            end
                        end else if (last || ts_i.eop) begin
                            sc_d     <= wnext;
                            sc_dval  <= 1'b1;
                            sc_sop   <= first;
                            sc_eop   <= 1'b1;
                            pkt_ok   <= last;
                            pkt_err  <= !last;
                            pack     <= '0;
                            byte_cnt <= '0;
                            first    <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            if (lane == 2'd3) begin
                                sc_d    <= wnext;
                                sc_dval <= 1'b1;
                                sc_sop  <= first;
                                first   <= 1'b0;
                                pack    <= '0;
                            end else begin
                                pack    <= wnext;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_pkt_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(pkt_ok),  .q(pkt_cnt)
    );
    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(pkt_err), .q(err_cnt)
    );
endmodule
